// File: rtl/qsys_multi_timer.sv
// Multi-channel interval timer: CHANNELS prescaled down-counters behind one
// 32-bit Avalon-MM slave, with per-channel timeout strobes and a shared irq.
module qsys_multi_timer #(
  parameter int          CHANNELS       = 4,
  parameter int          COUNTER_WIDTH  = 32,
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [31:0] RESET_PERIOD   = 32'd999999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(CHANNELS)+2:0] address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [CHANNELS-1:0]         timeout_pulse
);
  localparam int ADDR_W = $clog2(CHANNELS) + 3;
  localparam logic [COUNTER_WIDTH-1:0] PERIOD_INIT = RESET_PERIOD[COUNTER_WIDTH-1:0];

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  logic                wr_en;
  logic [2:0]          reg_sel;
  logic [ADDR_W-1:0]   ch_sel;
  logic [31:0]         rd_word [CHANNELS];
  logic [CHANNELS-1:0] irq_vec;
  logic [31:0]         rd_mux;

  assign wr_en   = chipselect && !write_n;
  assign reg_sel = address[2:0];
  assign ch_sel  = address >> 3;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [COUNTER_WIDTH-1:0]  period, counter, snap;
    logic [PRESCALE_WIDTH-1:0] prescale, pre_cnt;
    logic ito, cont, run, to, reload_pend, pulse;
    logic sel, wr_status, wr_ctrl, wr_period, wr_snap, wr_pre, start, stop;
    logic tick, expire;
    logic [31:0] word;

    assign sel       = wr_en && (ch_sel == ADDR_W'(i));
    assign wr_status = sel && (reg_sel == REG_STATUS);
    assign wr_ctrl   = sel && (reg_sel == REG_CONTROL);
    assign wr_period = sel && (reg_sel == REG_PERIOD);
    assign wr_snap   = sel && (reg_sel == REG_SNAP);
    assign wr_pre    = sel && (reg_sel == REG_PRESCALE);
    assign start     = wr_ctrl && writedata[2];
    assign stop      = wr_ctrl && writedata[3];

    // A PERIOD write and the following reload cycle both own the counter,
    // so any tick landing on either edge is swallowed without a timeout.
    assign tick   = run && (pre_cnt == '0);
    assign expire = tick && !wr_period && !reload_pend && (counter == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period      <= PERIOD_INIT;
        counter     <= PERIOD_INIT;
        snap        <= '0;
        prescale    <= '0;
        pre_cnt     <= '0;
        ito         <= 1'b0;
        cont        <= 1'b0;
        run         <= 1'b0;
        to          <= 1'b0;
        reload_pend <= 1'b0;
        pulse       <= 1'b0;
      end else begin
        pulse       <= expire;
        reload_pend <= wr_period;

        if (expire)         to <= 1'b1;
        else if (wr_status) to <= 1'b0;

        if (wr_ctrl) begin
          ito  <= writedata[0];
          cont <= writedata[1];
        end
        if (wr_period) period   <= writedata[COUNTER_WIDTH-1:0];
        if (wr_pre)    prescale <= writedata[PRESCALE_WIDTH-1:0];
        if (wr_snap)   snap     <= counter;

        if (reload_pend || expire)   counter <= period;
        else if (tick && !wr_period) counter <= counter - COUNTER_WIDTH'(1);

        if (start || wr_period || tick) pre_cnt <= prescale;
        else if (run)                   pre_cnt <= pre_cnt - PRESCALE_WIDTH'(1);

        if (start)                                         run <= 1'b1;
        else if (stop || wr_period || (expire && !cont))   run <= 1'b0;
      end
    end

    always_comb begin
      word = 32'd0;
      case (reg_sel)
        REG_STATUS:   word = {30'd0, run, to};
        REG_CONTROL:  word = {30'd0, cont, ito};
        REG_PERIOD:   word = 32'(period);
        REG_SNAP:     word = 32'(snap);
        REG_PRESCALE: word = 32'(prescale);
        default:      word = 32'd0;
      endcase
    end

    assign rd_word[i]       = word;
    assign irq_vec[i]       = to && ito;
    assign timeout_pulse[i] = pulse;
  end

  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch_sel == ADDR_W'(i)) rd_mux = rd_word[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 32'd0;
    else          readdata <= rd_mux;
  end

  assign irq = |irq_vec;
endmodule

// File: tb/tb_qsys_multi_timer.sv
// Bench for qsys_multi_timer: register table, hand-written corner sequences
// and random bus traffic compared every cycle against a behavioural model.
module tb_qsys_multi_timer;
  localparam int NCH = 4;
  localparam logic [31:0] RST_PERIOD = 32'd999999;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  timeout_pulse;

  qsys_multi_timer #(
    .CHANNELS(NCH), .COUNTER_WIDTH(32), .PRESCALE_WIDTH(16), .RESET_PERIOD(RST_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state, kept as plain per-channel numbers
  logic [31:0] m_period [NCH];
  logic [31:0] m_prescale [NCH];
  logic [31:0] m_count [NCH];
  logic [31:0] m_wait [NCH];
  logic [31:0] m_snap [NCH];
  bit   [3:0]  m_ito, m_cont, m_run, m_to, m_pend, m_pulse;
  logic [31:0] m_rd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int ch, input int rg);
    case (rg)
      0:       return {30'd0, m_run[ch], m_to[ch]};
      1:       return {30'd0, m_cont[ch], m_ito[ch]};
      2:       return m_period[ch];
      3:       return m_snap[ch];
      4:       return m_prescale[ch];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      m_period[c] = RST_PERIOD; m_count[c] = RST_PERIOD;
      m_prescale[c] = 0; m_wait[c] = 0; m_snap[c] = 0;
    end
    m_ito = 0; m_cont = 0; m_run = 0; m_to = 0; m_pend = 0; m_pulse = 0;
    m_rd = 0;
  endfunction

  function automatic void modelStep();
    int ch, rg;
    bit wr;
    logic [31:0] d;
    wr = chipselect && !write_n;
    ch = int'(address[4:3]);
    rg = int'(address[2:0]);
    d  = writedata;
    m_rd = modelRead(ch, rg);
    for (int c = 0; c < NCH; c++) begin
      bit hit, per_wr, start, stop, tick, timeout;
      hit     = wr && (ch == c);
      per_wr  = hit && rg == 2;
      start   = hit && rg == 1 && d[2];
      stop    = hit && rg == 1 && d[3];
      tick    = m_run[c] && m_wait[c] == 0;
      timeout = tick && !per_wr && !m_pend[c] && m_count[c] == 0;
      if (hit && rg == 3) m_snap[c] = m_count[c];
      if (m_pend[c] || timeout) m_count[c] = m_period[c];
      else if (tick && !per_wr) m_count[c] = m_count[c] - 1;
      if (start || per_wr || tick) m_wait[c] = m_prescale[c];
      else if (m_run[c])           m_wait[c] = m_wait[c] - 1;
      if (start) m_run[c] = 1'b1;
      else if (stop || per_wr || (timeout && !m_cont[c])) m_run[c] = 1'b0;
      if (timeout) m_to[c] = 1'b1;
      else if (hit && rg == 0) m_to[c] = 1'b0;
      if (hit && rg == 1) begin m_ito[c] = d[0]; m_cont[c] = d[1]; end
      if (per_wr) m_period[c] = d;
      if (hit && rg == 4) m_prescale[c] = d & 32'h0000_FFFF;
      m_pend[c]  = per_wr;
      m_pulse[c] = timeout;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) modelReset();
    else          modelStep();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_readdata", readdata, m_rd);
      checkOutput("model_irq", 32'(irq), 32'(|(m_to & m_ito)));
      checkOutput("model_timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    end
  end

  task automatic applyStimulus(input bit cs, input bit wr, input logic [4:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = !wr;
    address    = a;
    writedata  = d;
    @(negedge clk);
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
  endtask

  task automatic readReg(input logic [4:0] a);
    applyStimulus(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idleCycles(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int first, last, npulse, gap_bad, run_bad, r;
  logic [4:0]  a;
  logic [31:0] d;

  initial begin
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chipselect = 1'b1; address = 5'd2;
    @(negedge clk);
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_timeout_pulse", 32'(timeout_pulse), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Channel 0 register map after reset, plus write/readback behaviour
    vecs.push_back('{1'b0, 5'd0, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd1, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd2, 32'd0, 32'd999999});
    vecs.push_back('{1'b0, 5'd3, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd4, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd5, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd7, 32'd0, 32'd0});
    vecs.push_back('{1'b1, 5'd4, 32'hFFFF_0003, 32'd0});
    vecs.push_back('{1'b0, 5'd4, 32'd0, 32'd3});
    vecs.push_back('{1'b1, 5'd1, 32'h0000_000F, 32'd0});
    vecs.push_back('{1'b0, 5'd1, 32'd0, 32'd3});
    vecs.push_back('{1'b0, 5'd0, 32'd0, 32'd2});
    vecs.push_back('{1'b1, 5'd1, 32'h0000_0008, 32'd0});
    vecs.push_back('{1'b0, 5'd1, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd0, 32'd0, 32'd0});
    vecs.push_back('{1'b1, 5'd4, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 5'd4, 32'd0, 32'd0});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d", i), readdata, vecs[i].exp);
    end

    // Ch1 continuous, period 9: a pulse every 10 clocks, irq held until cleared
    writeReg(5'd10, 32'd9);
    writeReg(5'd12, 32'd0);
    writeReg(5'd9, 32'd7);
    chipselect = 1'b1; write_n = 1'b1; address = 5'd8;
    first = -1; last = -1; npulse = 0; gap_bad = 0; run_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (timeout_pulse[1]) begin
        if (first < 0) first = k;
        else if (k - last != 10) gap_bad++;
        last = k;
        npulse++;
      end
      if (k >= 2 && !readdata[1]) run_bad++;
      @(negedge clk);
    end
    checkOutput("ch1_first_pulse", 32'(first), 32'd11);
    checkOutput("ch1_pulse_count", 32'(npulse), 32'd3);
    checkOutput("ch1_pulse_gap", 32'(gap_bad), 32'd0);
    checkOutput("ch1_run_held", 32'(run_bad), 32'd0);
    checkOutput("ch1_irq_high", 32'(irq), 32'd1);
    checkOutput("ch1_status", readdata, 32'd3);
    writeReg(5'd8, 32'd0);
    checkOutput("ch1_irq_cleared", 32'(irq), 32'd0);
    writeReg(5'd9, 32'h8);

    // Ch2 one-shot, period 3, prescale 4: one pulse 20 clocks after START
    writeReg(5'd18, 32'd3);
    writeReg(5'd20, 32'd4);
    writeReg(5'd17, 32'd4);
    chipselect = 1'b1; write_n = 1'b1; address = 5'd16;
    first = -1; npulse = 0;
    for (int k = 1; k <= 45; k++) begin
      if (timeout_pulse[2]) begin
        if (first < 0) first = k;
        npulse++;
      end
      @(negedge clk);
    end
    checkOutput("ch2_pulse_time", 32'(first), 32'd21);
    checkOutput("ch2_pulse_count", 32'(npulse), 32'd1);
    checkOutput("ch2_stopped_status", readdata, 32'd1);
    checkOutput("ch2_no_irq", 32'(irq), 32'd0);
    writeReg(5'd19, 32'd0);
    readReg(5'd19);
    checkOutput("ch2_counter_held", readdata, 32'd3);
    writeReg(5'd16, 32'd0);

    // Ch0 PERIOD write mid-count stops the channel and reloads the counter
    writeReg(5'd1, 32'd4);
    idleCycles(5);
    writeReg(5'd2, 32'd100);
    readReg(5'd0);
    checkOutput("ch0_run_cleared", readdata, 32'd0);
    writeReg(5'd3, 32'd0);
    readReg(5'd3);
    checkOutput("ch0_snap_reload", readdata, 32'd100);

    // Ch3 period 0: timeout every clock beats a STATUS clear every clock
    writeReg(5'd26, 32'd0);
    writeReg(5'd28, 32'd0);
    writeReg(5'd25, 32'd6);
    npulse = 0;
    for (int j = 0; j < 6; j++) begin
      writeReg(5'd24, 32'd0);
      if (timeout_pulse[3]) npulse++;
    end
    checkOutput("ch3_pulse_every_clock", 32'(npulse), 32'd6);
    checkOutput("ch3_to_set_wins", readdata, 32'd3);
    writeReg(5'd25, 32'hC);
    readReg(5'd24);
    checkOutput("ch3_start_beats_stop", readdata & 32'd2, 32'd2);
    writeReg(5'd24, 32'd0);
    writeReg(5'd25, 32'h8);

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      a = 5'($urandom_range(0, 31));
      case (a[2:0])
        3'd1:    d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
        3'd2:    d = 32'($urandom_range(0, 12));
        3'd4:    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      if (r < 30)      applyStimulus(1'b1, 1'b1, a, d);
      else if (r < 40) applyStimulus(1'b0, 1'b1, a, d);
      else             applyStimulus(1'b1, 1'b0, a, d);
    end

    // Every channel running, then an asynchronous reset mid-count
    for (int c = 0; c < NCH; c++) begin
      writeReg(5'(c * 8 + 4), 32'd0);
      writeReg(5'(c * 8 + 2), 32'(5 + 2 * c));
      writeReg(5'(c * 8 + 1), 32'd7);
    end
    idleCycles(20);
    checkOutput("pre_reset_irq", 32'(irq), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_irq", 32'(irq), 32'd0);
    checkOutput("async_reset_pulse", 32'(timeout_pulse), 32'd0);
    checkOutput("async_reset_readdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      readReg(5'(c * 8));
      checkOutput($sformatf("post_reset_status%0d", c), readdata, 32'd0);
      writeReg(5'(c * 8 + 3), 32'd0);
      readReg(5'(c * 8 + 3));
      checkOutput($sformatf("post_reset_counter%0d", c), readdata, RST_PERIOD);
    end
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
